// File: rtl/vga_scanout.sv
// VGA timing generator and pixel-doubling scanout for a 320x240 framebuffer.
// fb_coords packs the read address as {x[8:0], y[7:0]}.
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [16:0] fb_coords,
    input  logic [2:0]  fb_color,
    output logic        new_frame,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic       phase_q, phase_d;
    logic       tick;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       blank_n_q, blank_n_d;
    logic [3:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       new_frame_q, new_frame_d;
    logic       vis_cur, vis_next;

    always_comb begin
        phase_d     = ~phase_q;
        tick        = phase_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        x_d         = x_q;
        y_d         = y_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        blank_n_d   = blank_n_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        new_frame_d = 1'b0;
        vis_cur     = (hcnt_q < H_VIS_W) && (vcnt_q < V_VIS_W);
        vis_next    = 1'b0;

        if (tick) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 10'd0;
                vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end

            // Read address tracks the post-advance position so the colour
            // returns in time for the next tick's output capture.
            vis_next = (hcnt_d < H_VIS_W) && (vcnt_d < V_VIS_W);
            x_d      = vis_next ? hcnt_d[9:1] : 9'd0;
            y_d      = vis_next ? vcnt_d[8:1] : 8'd0;

            hsync_d   = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
            vsync_d   = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
            blank_n_d = vis_cur;
            r_d       = vis_cur ? {4{fb_color[2]}} : 4'd0;
            g_d       = vis_cur ? {4{fb_color[1]}} : 4'd0;
            b_d       = vis_cur ? {4{fb_color[0]}} : 4'd0;

            new_frame_d = (hcnt_d == 10'd0) && (vcnt_d == V_VIS_W);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            phase_q     <= 1'b0;
            hcnt_q      <= 10'd0;
            vcnt_q      <= 10'd0;
            x_q         <= 9'd0;
            y_q         <= 8'd0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            blank_n_q   <= 1'b0;
            r_q         <= 4'd0;
            g_q         <= 4'd0;
            b_q         <= 4'd0;
            new_frame_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_n_q   <= blank_n_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            new_frame_q <= new_frame_d;
        end
    end

    assign fb_coords = {x_q, y_q};
    assign new_frame = new_frame_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign blank_n   = blank_n_q;
    assign vga_r     = r_q;
    assign vga_g     = g_q;
    assign vga_b     = b_q;
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench: full-size instance (line timing, colour path) and a
// reduced-timing instance (frame timing, new_frame, blanking with colour 7).
module tb_vga_scanout;
    typedef struct packed {
        logic [16:0] coords;
        logic        nf;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic [16:0] coords_a, coords_b;
    logic [2:0]  color_a = 3'd0, color_b = 3'd7;
    logic        nf_a, hs_a, vs_a, bn_a, nf_b, hs_b, vs_b, bn_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    vga_scanout u_full (
        .Clk(clk), .Reset(rst), .fb_coords(coords_a), .fb_color(color_a),
        .new_frame(nf_a), .hsync(hs_a), .vsync(vs_a), .blank_n(bn_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    vga_scanout #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .Clk(clk), .Reset(rst), .fb_coords(coords_b), .fb_color(color_b),
        .new_frame(nf_b), .hsync(hs_b), .vsync(vs_b), .blank_n(bn_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    int checks = 0;
    int errors = 0;
    obs_t qa[$];
    obs_t qb[$];

    // Expected outputs after the n-th rising edge since reset was released
    // (n = 0 means the edge sampled Reset high).
    function automatic obs_t model(int n, int hv, int hfp, int hsw, int hbp,
                                   int vv, int vfp, int vsw, int vbp, bit const7);
        obs_t o;
        int ht, vt, k, hk, vk, p, h, v;
        logic [2:0] c;
        ht = hv + hfp + hsw + hbp;
        vt = vv + vfp + vsw + vbp;
        k  = n / 2;
        o  = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        hk = k % ht;
        vk = (k / ht) % vt;
        if (hk < hv && vk < vv) o.coords = {9'(hk / 2), 8'(vk / 2)};
        o.nf = (n % 2 == 0) && (k > 0) && (hk == 0) && (vk == vv);
        if (k > 0) begin
            p = k - 1;
            h = p % ht;
            v = (p / ht) % vt;
            o.hs = !(h >= hv + hfp && h < hv + hfp + hsw);
            o.vs = !(v >= vv + vfp && v < vv + vfp + vsw);
            o.bn = (h < hv) && (v < vv);
            c = const7 ? 3'd7 : 3'((h / 2 + v / 2) & 7);
            if (o.bn) begin
                o.r = {4{c[2]}};
                o.g = {4{c[1]}};
                o.b = {4{c[0]}};
            end
        end
        return o;
    endfunction

    // Framebuffer model for the full instance: colour (x+y)&7, one Clk latency.
    initial begin
        logic [2:0] pending;
        pending = 3'd0;
        forever begin
            @(negedge clk);
            color_a = pending;
            pending = 3'((coords_a[16:8] + 9'(coords_a[7:0])) & 9'd7);
        end
    end

    // Stimulus side: push the expected observation for every edge.
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            if (rst) n = 0;
            else n++;
            qa.push_back(model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            qb.push_back(model(n, 16, 2, 4, 2, 8, 1, 2, 2, 1'b1));
        end
    end

    task automatic check_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: one observation per Clk per instance, plus run-length timing.
    initial begin
        obs_t ea, eb, ga, gb;
        int cyc, nmon, last_fall, hs_len, bn_len, last_nf, nf_count;
        bit prev_hs, prev_bn, hs_cnt, bn_cnt, first_fall;
        cyc = 0; nmon = 0; last_fall = -1; hs_len = 0; bn_len = 0;
        last_nf = -1; nf_count = 0;
        prev_hs = 1'b1; prev_bn = 1'b0; hs_cnt = 1'b0; bn_cnt = 1'b0; first_fall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            ga = {coords_a, nf_a, hs_a, vs_a, bn_a, r_a, g_a, b_a};
            gb = {coords_b, nf_b, hs_b, vs_b, bn_b, r_b, g_b, b_b};
            checks++;
            if (qa.size() == 0 || qb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty got %0d/%0d entries required >0", qa.size(), qb.size());
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                if (ga !== ea) begin
                    errors++;
                    $display("FAIL full_obs n=%0d got %h expected %h", nmon + (rst ? 0 : 1), ga, ea);
                end
                checks++;
                if (gb !== eb) begin
                    errors++;
                    $display("FAIL small_obs n=%0d got %h expected %h", nmon + (rst ? 0 : 1), gb, eb);
                end
            end

            if (rst) begin
                nmon = 0; last_fall = -1; last_nf = -1;
                hs_cnt = 1'b0; bn_cnt = 1'b0; first_fall = 1'b1;
            end else begin
                nmon++;
                if (!hs_a && prev_hs) begin
                    if (first_fall) check_int("hsync_first_fall_clk", nmon, 2 * 657);
                    first_fall = 1'b0;
                    if (last_fall >= 0) check_int("hsync_period", cyc - last_fall, 1600);
                    last_fall = cyc;
                    hs_len = 0;
                    hs_cnt = 1'b1;
                end
                if (!hs_a) hs_len++;
                if (hs_a && !prev_hs && hs_cnt) check_int("hsync_low_width", hs_len, 192);
                if (bn_a && !prev_bn) begin
                    bn_len = 0;
                    bn_cnt = 1'b1;
                end
                if (bn_a) bn_len++;
                if (!bn_a && prev_bn && bn_cnt) check_int("blank_n_high_width", bn_len, 1280);
                if (nf_b) begin
                    nf_count++;
                    if (last_nf >= 0) check_int("new_frame_spacing", cyc - last_nf, 624);
                    last_nf = cyc;
                end
            end
            prev_hs = hs_a;
            prev_bn = bn_a;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (900) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4900) @(negedge clk);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
